// File: rtl/cpu_paddle_controller_pkg.sv
// Shared pong definitions: display geometry defaults, CPU opponent state encoding, row clamp helper.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package cpu_paddle_controller_pkg;

    localparam int ROW_W             = 12;
    localparam int DISP_COLS_DEF     = 800;
    localparam int DISP_ROWS_DEF     = 600;
    localparam int PADDLE_HEIGHT_DEF = 44;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REACT = 2'd1,
        TRACK = 2'd2
    } cpu_state_e;

    // Keeps the chase target inside the range the paddle centre can physically reach.
    function automatic logic [ROW_W-1:0] clamp_row(
        input logic [ROW_W-1:0] row,
        input logic [ROW_W-1:0] lo,
        input logic [ROW_W-1:0] hi
    );
        if (row < lo) begin
            return lo;
        end else if (row > hi) begin
            return hi;
        end else begin
            return row;
        end
    endfunction

endpackage

// File: rtl/cpu_paddle_controller_error_hysteresis.sv
// Turns (target row - current row) into registered up/down requests with start/stop deadband hysteresis.
// Latency: one clk from an enabled cycle to the output update; outputs hold while en is low.
// Backpressure: none; outputs are levels sampled by the paddle mover whenever it likes.
module paddle_error_hysteresis
    import cpu_paddle_controller_pkg::*;
#(
    parameter int START_BAND = 8,
    parameter int STOP_BAND  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ROW_W-1:0] target_row,
    input  logic [ROW_W-1:0] current_row,
    output logic             moving,
    output logic             move_up,
    output logic             move_down
);

    localparam logic [ROW_W-1:0] START_LIM = ROW_W'(START_BAND);
    localparam logic [ROW_W-1:0] STOP_LIM  = ROW_W'(STOP_BAND);

    logic [ROW_W:0]   err;
    logic [ROW_W-1:0] err_mag;
    logic             moving_q, moving_d;
    logic             up_q, up_d;
    logic             down_q, down_d;

    // Signed 13-bit error; its magnitude always fits back into 12 bits.
    always_comb begin
        err     = {1'b0, target_row} - {1'b0, current_row};
        err_mag = ROW_W'(err[ROW_W] ? (-err) : err);
    end

    // Hysteresis update: start beyond the wide band, stop inside the narrow one; direction follows the error sign.
    always_comb begin
        moving_d = moving_q;
        up_d     = up_q;
        down_d   = down_q;
        if (en) begin
            if (!moving_q && (err_mag > START_LIM)) begin
                moving_d = 1'b1;
            end else if (moving_q && (err_mag <= STOP_LIM)) begin
                moving_d = 1'b0;
            end
            up_d   = moving_d && err[ROW_W];
            down_d = moving_d && !err[ROW_W] && (err != '0);
        end
    end

    // Output registers; reset drops any request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moving_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            moving_q <= moving_d;
            up_q     <= up_d;
            down_q   <= down_d;
        end
    end

    assign moving    = moving_q;
    assign move_up   = up_q;
    assign move_down = down_q;

endmodule

// File: rtl/cpu_paddle_controller.sv
// CPU opponent: per-frame approach detection, reaction delay, then chases the clamped ball row.
// Latency: one clk from frame_tick to any output change; outputs hold between ticks.
// Backpressure: none; drives move_up/move_down levels straight into the paddle mover.
module cpu_paddle_controller
    import cpu_paddle_controller_pkg::*;
#(
    parameter int DISP_COLS       = DISP_COLS_DEF,
    parameter int DISP_ROWS       = DISP_ROWS_DEF,
    parameter int PADDLE_HEIGHT   = PADDLE_HEIGHT_DEF,
    parameter int PADDLE_SIDE     = 1,
    parameter int REACTION_FRAMES = 6,
    parameter int START_BAND      = 8,
    parameter int STOP_BAND       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic [ROW_W-1:0] ball_row,
    input  logic [ROW_W-1:0] ball_col,
    input  logic [ROW_W-1:0] paddle_center_row,
    output logic             move_up_control,
    output logic             move_down_control,
    output logic             chasing
);

    localparam logic [ROW_W-1:0] CENTER_ROW = ROW_W'(DISP_ROWS / 2);
    localparam logic [ROW_W-1:0] ROW_MIN    = ROW_W'(PADDLE_HEIGHT / 2);
    localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(DISP_ROWS - 1 - PADDLE_HEIGHT / 2);
    localparam logic [ROW_W-1:0] COL_RESET  = ROW_W'(DISP_COLS / 2);
    localparam logic [7:0]       REACT_LOAD = 8'(REACTION_FRAMES);

    cpu_state_e       state_q, state_d;
    logic [ROW_W-1:0] prev_col_q, prev_col_d;
    logic [7:0]       count_q, count_d;
    logic             approach_q, approach_d;
    logic             chasing_q, chasing_d;
    logic [ROW_W-1:0] target_row;
    logic             moving;

    // Per-tick direction verdict and state machine; an unchanged column keeps the last verdict.
    always_comb begin
        state_d    = state_q;
        prev_col_d = prev_col_q;
        count_d    = count_q;
        approach_d = approach_q;
        if (frame_tick) begin
            prev_col_d = ball_col;
            if (PADDLE_SIDE != 0) begin
                if (ball_col > prev_col_q) begin
                    approach_d = 1'b1;
                end else if (ball_col < prev_col_q) begin
                    approach_d = 1'b0;
                end
            end else begin
                if (ball_col < prev_col_q) begin
                    approach_d = 1'b1;
                end else if (ball_col > prev_col_q) begin
                    approach_d = 1'b0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (approach_d) begin
                        if (REACT_LOAD == 8'd0) begin
                            state_d = TRACK;
                        end else begin
                            state_d = REACT;
                            count_d = REACT_LOAD;
                        end
                    end
                end
                REACT: begin
                    if (!approach_d) begin
                        state_d = IDLE;
                        count_d = 8'd0;
                    end else if (count_q <= 8'd1) begin
                        state_d = TRACK;
                        count_d = 8'd0;
                    end else begin
                        count_d = count_q - 8'd1;
                    end
                end
                TRACK: begin
                    if (!approach_d) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Target follows the state being entered, so a new chase shows up on the same tick's outputs.
    always_comb begin
        target_row = (state_d == TRACK) ? clamp_row(ball_row, ROW_MIN, ROW_MAX) : CENTER_ROW;
        chasing_d  = (state_d == TRACK);
    end

    // State, direction history and reaction counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_col_q <= COL_RESET;
            count_q    <= 8'd0;
            approach_q <= 1'b0;
            chasing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_col_q <= prev_col_d;
            count_q    <= count_d;
            approach_q <= approach_d;
            chasing_q  <= chasing_d;
        end
    end

    // The moving flag deliberately survives state changes; only the target feeding it switches.
    paddle_error_hysteresis #(
        .START_BAND (START_BAND),
        .STOP_BAND  (STOP_BAND)
    ) u_hyst (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (frame_tick),
        .target_row  (target_row),
        .current_row (paddle_center_row),
        .moving      (moving),
        .move_up     (move_up_control),
        .move_down   (move_down_control)
    );

    assign chasing = chasing_q;

endmodule

// File: tb/tb_cpu_paddle_controller.sv
// Directed scoreboard bench for cpu_paddle_controller with default parameters (right paddle, 6-frame reaction).
// Each frame tick pushes its expected outputs; a monitor compares one clk later on the falling edge.
// Immediate checks (reset behaviour) use chk_req to trigger the same monitor.
module tb_cpu_paddle_controller;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic [11:0] ball_row;
    logic [11:0] ball_col;
    logic [11:0] paddle_center_row;
    logic        move_up_control;
    logic        move_down_control;
    logic        chasing;

    typedef struct {
        logic  up;
        logic  down;
        logic  chase;
        string name;
    } exp_t;

    exp_t exp_q[$];

    int   errors = 0;
    int   checks = 0;
    bit   tick_d = 1'b0;
    bit   chk_req = 1'b0;
    bit   final_chk = 1'b0;
    bit   final_done = 1'b0;
    logic [11:0] c;

    cpu_paddle_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_tick        (frame_tick),
        .ball_row          (ball_row),
        .ball_col          (ball_col),
        .paddle_center_row (paddle_center_row),
        .move_up_control   (move_up_control),
        .move_down_control (move_down_control),
        .chasing           (chasing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Marks the cycle after a tick as the one where outputs are due.
    always @(posedge clk) tick_d <= frame_tick;

    // Monitor: pops one expectation per output event and compares all three outputs.
    always @(negedge clk) begin
        exp_t e;
        if (tick_d || chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got up=%0b down=%0b chasing=%0b, no expectation queued",
                         move_up_control, move_down_control, chasing);
            end else begin
                e = exp_q.pop_front();
                if (move_up_control !== e.up || move_down_control !== e.down || chasing !== e.chase) begin
                    errors++;
                    $display("FAIL %s: got up=%0b down=%0b chasing=%0b, want up=%0b down=%0b chasing=%0b",
                             e.name, move_up_control, move_down_control, chasing, e.up, e.down, e.chase);
                end
            end
        end
        if (final_chk && !final_done) begin
            final_done = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: got %0d unchecked expectations, want 0", exp_q.size());
            end
        end
    end

    task automatic push_exp(input logic eu, input logic ed, input logic ec, input string nm);
        exp_t e;
        e.up    = eu;
        e.down  = ed;
        e.chase = ec;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Drives one frame tick; consecutive calls give back-to-back ticks.
    task automatic tick(input logic [11:0] col, input logic [11:0] row, input logic [11:0] pad,
                        input logic eu, input logic ed, input logic ec, input string nm);
        @(posedge clk);
        #1;
        ball_col          = col;
        ball_row          = row;
        paddle_center_row = pad;
        frame_tick        = 1'b1;
        push_exp(eu, ed, ec, nm);
    endtask

    task automatic gap(input int n);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Immediate check in the current cycle, with no tick in flight.
    task automatic check_now(input logic eu, input logic ed, input logic ec, input string nm);
        @(posedge clk);
        #1;
        push_exp(eu, ed, ec, nm);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        frame_tick        = 1'b0;
        ball_col          = 12'd600;
        ball_row          = 12'd100;
        paddle_center_row = 12'd300;

        // Reset held, ball far right of the reset prev_col
        repeat (2) @(posedge clk);
        check_now(1'b0, 1'b0, 1'b0, "reset_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check_now(1'b0, 1'b0, 1'b0, "post_reset_no_tick");

        // Centre hold: ball moving away (equal column first keeps the "away" verdict)
        tick(12'd400, 12'd100, 12'd300, 1'b0, 1'b0, 1'b0, "idle_equal_col"); gap(2);
        tick(12'd390, 12'd100, 12'd300, 1'b0, 1'b0, 1'b0, "idle_away_390");  gap(2);
        tick(12'd380, 12'd100, 12'd300, 1'b0, 1'b0, 1'b0, "idle_away_380");  gap(2);
        tick(12'd370, 12'd100, 12'd300, 1'b0, 1'b0, 1'b0, "idle_away_370");  gap(2);

        // Reaction delay on back-to-back ticks: chase and move_up on the 7th approaching tick
        for (int i = 0; i < 7; i++) begin
            tick(12'(400 + 10 * i), 12'd100, 12'd300, (i == 6), 1'b0, (i == 6),
                 $sformatf("react_tick%0d", i + 1));
        end
        gap(2);

        // Hysteresis in TRACK, target row 100
        c = 12'd470;
        tick(c, 12'd100, 12'd200, 1'b1, 1'b0, 1'b1, "hyst_pad200");   gap(1); c = c + 12'd10;
        tick(c, 12'd100, 12'd103, 1'b1, 1'b0, 1'b1, "hyst_err_m3");   gap(1); c = c + 12'd10;
        tick(c, 12'd100, 12'd102, 1'b0, 1'b0, 1'b1, "hyst_err_m2");   gap(1); c = c + 12'd10;
        tick(c, 12'd100, 12'd107, 1'b0, 1'b0, 1'b1, "hyst_err_m7");   gap(1); c = c + 12'd10;
        tick(c, 12'd100, 12'd109, 1'b1, 1'b0, 1'b1, "hyst_err_m9");   gap(1); c = c + 12'd10;
        tick(c, 12'd100, 12'd95,  1'b0, 1'b1, 1'b1, "hyst_reverse");  gap(1); c = c + 12'd10;
        tick(c, 12'd100, 12'd100, 1'b0, 1'b0, 1'b1, "hyst_err_zero"); gap(1);
        tick(c, 12'd100, 12'd300, 1'b1, 1'b0, 1'b1, "track_equal_col"); gap(1); c = c + 12'd10;

        // Clamp: low target 22, high target 577
        tick(c, 12'd5,   12'd100, 1'b1, 1'b0, 1'b1, "clamp_lo_start"); gap(1); c = c + 12'd10;
        tick(c, 12'd5,   12'd30,  1'b1, 1'b0, 1'b1, "clamp_lo_m8");    gap(1); c = c + 12'd10;
        tick(c, 12'd5,   12'd24,  1'b0, 1'b0, 1'b1, "clamp_lo_stop");  gap(1); c = c + 12'd10;
        tick(c, 12'd5,   12'd20,  1'b0, 1'b0, 1'b1, "clamp_lo_no_up"); gap(1); c = c + 12'd10;
        tick(c, 12'd5,   12'd12,  1'b0, 1'b1, 1'b1, "clamp_lo_p10");   gap(1); c = c + 12'd10;
        tick(c, 12'd598, 12'd500, 1'b0, 1'b1, 1'b1, "clamp_hi_start"); gap(1); c = c + 12'd10;
        tick(c, 12'd598, 12'd575, 1'b0, 1'b0, 1'b1, "clamp_hi_stop");  gap(1); c = c + 12'd10;
        tick(c, 12'd598, 12'd585, 1'b0, 1'b0, 1'b1, "clamp_hi_m8");    gap(1); c = c + 12'd10;
        tick(c, 12'd598, 12'd586, 1'b1, 1'b0, 1'b1, "clamp_hi_m9");    gap(1);

        // Ball leaves: back to IDLE while still moving, target becomes centre
        c = c - 12'd10;
        tick(c, 12'd598, 12'd586, 1'b1, 1'b0, 1'b0, "idle_keeps_moving"); gap(1); c = c - 12'd10;
        tick(c, 12'd598, 12'd300, 1'b0, 1'b0, 1'b0, "idle_centred");      gap(1);

        // Abort from REACT when the ball reverses
        c = c + 12'd10;
        tick(c, 12'd100, 12'd300, 1'b0, 1'b0, 1'b0, "abort_react1"); gap(1); c = c + 12'd10;
        tick(c, 12'd100, 12'd300, 1'b0, 1'b0, 1'b0, "abort_react2"); gap(1); c = c - 12'd10;
        tick(c, 12'd100, 12'd250, 1'b0, 1'b1, 1'b0, "abort_idle_down"); gap(1);
        tick(c, 12'd100, 12'd290, 1'b0, 1'b1, 1'b0, "abort_err_p10");   gap(1);
        tick(c, 12'd100, 12'd297, 1'b0, 1'b1, 1'b0, "abort_err_p3");    gap(1);
        tick(c, 12'd100, 12'd298, 1'b0, 1'b0, 1'b0, "abort_err_p2");    gap(1);

        // Reaction count reloads after the abort
        for (int i = 0; i < 7; i++) begin
            c = c + 12'd5;
            tick(c, 12'd300, 12'd300, 1'b0, 1'b0, (i == 6), $sformatf("reload_tick%0d", i + 1));
        end
        gap(2);

        // Reset mid-motion: outputs must fall before the next clock edge
        c = c + 12'd5;
        tick(c, 12'd100, 12'd300, 1'b1, 1'b0, 1'b1, "pre_reset_motion"); gap(2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        push_exp(1'b0, 1'b0, 1'b0, "async_reset_mid_motion");
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        tick(12'd390, 12'd100, 12'd300, 1'b0, 1'b0, 1'b0, "post_reset_idle"); gap(3);

        final_chk = 1'b1;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_paddle_controller.md
Name: cpu_paddle_controller

Overview:
- Computer opponent that generates the move_up_control / move_down_control levels consumed by the paddle mover; it is the producer end of the paddle control interface.
- Observes ball position once per video frame, decides chase vs. return-to-centre, and drives the two control levels with deadband hysteresis and a programmable reaction delay.
- Instantiated once per CPU-controlled side, in place of the debounced player buttons.

Parameters:
- DISP_COLS, 800, visible columns.
- DISP_ROWS, 600, visible rows.
- PADDLE_HEIGHT, 44, paddle height in rows.
- PADDLE_SIDE, 1, 0 = left paddle (ball approaches when col decreases), 1 = right paddle (ball approaches when col increases).
- REACTION_FRAMES, 6, frames between detecting an approaching ball and starting to chase (0..255).
- START_BAND, 8, error magnitude in rows above which motion starts.
- STOP_BAND, 2, error magnitude in rows at or below which motion stops; must be less than START_BAND.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- frame_tick  input  1  single-cycle pulse, once per frame
- ball_row  input  12  ball centre row
- ball_col  input  12  ball centre column
- paddle_center_row  input  12  current paddle centre from the paddle mover
- move_up_control  output  1  level; request row decrement
- move_down_control  output  1  level; request row increment
- chasing  output  1  high while in the TRACK state (debug/LED)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prev_col=DISP_COLS/2, reaction count=0, both move outputs 0, chasing 0, moving flag 0. All outputs registered.
- All decisions are evaluated only on cycles where frame_tick=1. Outputs hold between ticks. Latency is one clk from the tick to the output change.
- Approach detection uses the current ball_col and prev_col. prev_col is updated on every tick.
  - Approaching: ball_col > prev_col when PADDLE_SIDE=1, ball_col < prev_col when PADDLE_SIDE=0.
  - Equal columns keep the previous direction verdict, which resets to "away".
- States:
  - IDLE: target = DISP_ROWS/2. When approaching is detected, go to REACT and load count = REACTION_FRAMES. If REACTION_FRAMES = 0, go straight to TRACK on the same tick.
  - REACT: target stays at centre. Decrement count each tick; when count reaches 0, go to TRACK. If the ball is detected moving away, return to IDLE.
  - TRACK: target = ball_row clamped to [PADDLE_HEIGHT/2, DISP_ROWS-1-PADDLE_HEIGHT/2]. chasing=1. Away-detection returns to IDLE.
- Error: err = target - paddle_center_row, computed as 13-bit signed; |err| is at most 12 bits.
- Hysteresis via the moving flag:
  - If moving=0 and |err| > START_BAND: set moving=1.
  - If moving=1 and |err| <= STOP_BAND: clear moving=1.
  - Outputs: move_down=moving and err>0; move_up=moving and err<0.
  - move_up and move_down are never simultaneously 1. err=0 forces both to 0.
- A state change does not clear the moving flag; the new target simply feeds the same comparator. Example: IDLE to TRACK with the paddle already moving keeps it moving.
- frame_tick asserted on consecutive cycles: each cycle is treated as a frame, with no special casing.
- Reset mid-motion: outputs drop to 0 asynchronously.

Decomposition:
- Shared pong package: DISP_COLS/DISP_ROWS defaults, PADDLE_HEIGHT, and the state enum (IDLE, REACT, TRACK).
- One natural sub-module, paddle_error_hysteresis. It takes the target and current row and produces moving/up/down with the START/STOP bands. It is reusable for an attract-mode demo paddle.

Test Plan:
- Reset: hold rst_n=0 with the ball approaching -> outputs 0, chasing 0. Release, no ticks -> outputs stay 0.
- Centre hold in IDLE: paddle=300, ball moving away (PADDLE_SIDE=1, col decreasing 500→490) -> no movement on any tick.
- Reaction delay:
  - Setup: PADDLE_SIDE=1, REACTION_FRAMES=6, paddle=300, ball_row=100, col 400→410→420…
  - Required: chasing rises on the 7th approaching tick, and move_up=1 one clk after that tick.
  - Required: move_down=0 throughout.
- Hysteresis:
  - In TRACK with target=100 and paddle stepped 300→103 -> move_up stays 1.
  - Paddle=102 -> move_up=0 after the next tick.
  - Paddle drifts to 107 (err=-7) -> stays idle. Paddle=109 (err=-9) -> move_up re-asserts.
- Clamp: in TRACK, ball_row=5 -> the paddle stops at |err|<=2 around 22, never requesting up below row 20. ball_row=598 -> stop near 577.
- Abort: in REACT, the ball reverses direction (col 420→410) -> state=IDLE. Paddle=250 then drives move_down until within 2 of 300. chasing stays 0.
